// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared state encoding and default latencies for the pipeline hazard controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  localparam int MDU_LAT_DEF     = 32;
  localparam int MEM_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_counter.sv
// Tracks MDU occupancy: a start loads MDU_LAT-1, then the count drains to zero.
// busy is registered state only, so it is 0 in the cycle the operation launches.
module mdu_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(MDU_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

`ifndef SYNTHESIS
  // A second mult/div launch while the unit is occupied is illegal software.
  a_no_restart_busy : assert property (@(posedge clk) disable iff (!rst_n) !(start && busy));
`endif

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hold/bubble/flush generation for the 5-stage pipe; all controls are combinational
// (0-cycle), priority mem_stall > taken branch > load-use | MDU; outputs forced low in reset.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT     = MDU_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_mdu_use,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_mdu_start,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       stall_front,
  output logic       bubble_idex,
  output logic       stall_back,
  output logic       flush_ifid,
  output logic       mdu_busy,
  output logic       mem_err
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  hz_state_e     state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic busy;
  logic timeout;
  logic mem_stall;
  logic load_use;
  logic mdu_hazard;

  mdu_busy_counter #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ex_mdu_start),
    .busy  (busy)
  );

  assign timeout   = (state_q == ST_MEM_WAIT) && (tmo_cnt_q == TW'(MEM_TIMEOUT - 1));
  assign mem_stall = ((state_q == ST_RUN) && mem_req && !mem_ack) ||
                     ((state_q == ST_MEM_WAIT) && !mem_ack && !timeout);

  assign load_use   = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mdu_hazard = id_mdu_use && busy;

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = '0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack || timeout) begin
          state_d = ST_RUN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // A frozen pipe squashes nothing; a taken branch kills the ID instr, so its stalls are moot.
  always_comb begin
    stall_front = 1'b0;
    bubble_idex = 1'b0;
    stall_back  = 1'b0;
    flush_ifid  = 1'b0;
    if (mem_stall) begin
      stall_front = 1'b1;
      stall_back  = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (load_use || mdu_hazard) begin
      stall_front = 1'b1;
      bubble_idex = 1'b1;
    end
    if (!rst_n) begin
      stall_front = 1'b0;
      bubble_idex = 1'b0;
      stall_back  = 1'b0;
      flush_ifid  = 1'b0;
    end
  end

  assign mdu_busy = rst_n && busy;
  assign mem_err  = rst_n && timeout && !mem_ack;

endmodule
